muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU of the pipelined core. It executes MULT/MULTU/DIV/DIVU over WIDTH-bit operands with a busy/done handshake the hazard logic uses to stall, and it services MTHI/MTLO writes and MFHI/MFLO reads. Signed operations run on a shared unsigned shift/add–subtract core with sign correction at the end.

## Interface
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- reset_in  in  1  reset, asynchronous and active-high.
- start_in  in  1  request to launch an operation; sampled only in IDLE or DONE.
- op_in  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_in  in  WIDTH  multiplicand or dividend.
- b_in  in  WIDTH  multiplier or divisor.
- hi_wr_in  in  1  MTHI write strobe.
- lo_wr_in  in  1  MTLO write strobe.
- wr_data_in  in  WIDTH  data for MTHI/MTLO.
- busy_out  out  1  operation in flight; the hazard unit stalls on it.
- done_out  out  1  one-cycle pulse when HI/LO take a new result.
- hi_out  out  WIDTH  HI register: remainder or product upper half.
- lo_out  out  WIDTH  LO register: quotient or product lower half.

## Operation
- States are IDLE, CALC, FIX, DONE.
- **Launch:** a start_in seen in IDLE or DONE latches op, operand magnitudes, operand signs and the div-by-zero flag, clears the iteration counter, and moves to CALC.
- **CALC:** one radix-2 step per cycle for exactly WIDTH cycles.
  - Multiply uses shift-add into a 2·WIDTH accumulator.
  - Divide uses restoring division: the remainder shifts left and a trial subtract sets one quotient bit.
- **FIX:** applies the sign rules, writes HI/LO, and moves to DONE.
  - Product negated if sa^sb.
  - Quotient negated if sa^sb.
  - Remainder negated if sa.
- **DONE:** lasts one cycle, then IDLE; a start_in seen in DONE launches directly to CALC.
- **Signed overflow:** DIV of 0x80…0 by −1 gives LO = 0x80…0 and HI = 0. This is the wrap result; no trap.
- **Divide by zero (DIV or DIVU):** HI = a_in unmodified and LO = all ones. Sign correction is bypassed.
- **Starts while busy:** start_in in CALC or FIX is ignored. No queueing.
- **MTHI/MTLO:** applied at the edge in IDLE or DONE only; ignored in CALC and FIX.
  - A write on the same edge as a launch takes effect, and the finishing operation later overwrites it.
  - If hi_wr_in and lo_wr_in are both high, both registers take wr_data_in.
- **Reads:** hi_out and lo_out are held registers; they change only at the FIX→DONE edge, on MTHI/MTLO, or on reset.

## Timing
- **Reset values:** state IDLE, busy_out = 0, done_out = 0, hi_out = 0, lo_out = 0, counter = 0.
- **Reset mid-operation:** the result is discarded immediately, with no done pulse.
- **Normal latency** (start sampled at edge E0):
  - busy_out is high from after E0 through E(WIDTH+1).
  - HI/LO update and done_out rise after E(WIDTH+1).
  - done_out falls after E(WIDTH+2) unless a new launch follows.
- **Throughput:** one operation per WIDTH+2 cycles back-to-back, with a start presented in DONE.
- busy_out and done_out are never high together.
- **Counter:** $clog2(WIDTH)+1 bits. FIX is entered when the counter reaches WIDTH−1 at the edge; there is no wrap.

## Configuration
- **MULDIV_EARLY_OUT_EN defined:** at launch, the unit goes IDLE→FIX, skipping CALC, in these cases:
  - a multiply with a_in == 0 or b_in == 0; the result is HI = LO = 0.
  - a divide with b_in == 0; the result is the divide-by-zero values above.
  - In both cases done_out rises after E1 and busy_out is high for one cycle only.
- **MULDIV_EARLY_OUT_EN not defined:** every operation takes the full WIDTH+2 latency. Results are identical either way.

## Structure
- Package muldiv_pkg holds:
  - the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - the state encoding (ST_IDLE, ST_CALC, ST_FIX, ST_DONE).
- Sub-module muldiv_sign_fix is combinational and parametrised by width. It performs conditional two's-complement negation and is instantiated for:
  - the operand magnitudes at launch.
  - the result correction in FIX.

## Test plan
All scenarios use WIDTH = 32.
- **MULT** a = 0xFFFFFFFD (−3), b = 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; done_out after edge 33; busy high for exactly 33 cycles.
- **MULTU** 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **DIVU and DIV:**
  - DIVU 100/7 → LO = 14, HI = 2.
  - DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **DIVU 0x1234/0:**
  - Result HI = 0x1234, LO = 0xFFFFFFFF.
  - Latency is 34 edges without MULDIV_EARLY_OUT_EN and 2 edges with it.
- **Busy behaviour:**
  - start_in and hi_wr_in (0xAAAA) are pulsed mid-CALC → both ignored, and the original result lands.
  - hi_wr_in with 0x55 in IDLE → hi_out = 0x55 next cycle, lo_out unchanged.
- **Reset and back-to-back:**
  - reset_in asserted at CALC cycle 10 → busy_out, done_out, HI and LO are 0 immediately, with no done pulse afterward.
  - A back-to-back start in DONE gives a second done exactly 34 cycles after the first.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package muldiv_pkg;

    // op_in encoding
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Control FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Upper op bit selects divide, low bit clear means signed.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation of a W-bit value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Negation wraps naturally, so the most negative value maps to itself.
    assign result = negate ? (~value + ONE) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; optional MULDIV_EARLY_OUT_EN.
// Latency: WIDTH+2 cycles launch to done (2 cycles for trivial ops with MULDIV_EARLY_OUT_EN).
// Backpressure: busy_out stalls the pipe; starts and MTHI/MTLO are dropped while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             hi_wr_in,
    input  logic             lo_wr_in,
    input  logic [WIDTH-1:0] wr_data_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 4) begin : g_width_check
        $error("muldiv_unit: WIDTH must be at least 4");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               div_q;      // operation in flight is a divide
    logic               sa_q;       // operand A was negative (signed ops only)
    logic               sb_q;       // operand B was negative (signed ops only)
    logic               div0_q;     // divide with zero divisor
    logic [WIDTH-1:0]   mag_a_q;    // |A|: multiplicand, or dividend kept for div-by-zero
    logic [WIDTH-1:0]   mag_b_q;    // |B|: multiplier seed or divisor
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial hi, shifting multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // ------------------------------------------------------------------
    // Launch decode: operand magnitudes and signs
    // ------------------------------------------------------------------
    logic             can_launch;
    logic             launch;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             early_out;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign can_launch = (state == ST_IDLE) || (state == ST_DONE);
    assign launch     = can_launch && start_in;
    assign a_neg      = op_is_signed(op_in) && a_in[WIDTH-1];
    assign b_neg      = op_is_signed(op_in) && b_in[WIDTH-1];
    assign b_zero     = (b_in == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic a_zero;
    assign a_zero    = (a_in == '0);
    // Zero operand multiply or zero divisor: result is known without iterating.
    assign early_out = op_is_div(op_in) ? b_zero : (a_zero || b_zero);
`else
    assign early_out = 1'b0;
`endif

    muldiv_sign_fix #(.W(WIDTH)) u_fix_a (
        .value  (a_in),
        .negate (a_neg),
        .result (a_mag)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_b (
        .value  (b_in),
        .negate (b_neg),
        .result (b_mag)
    );

    // ------------------------------------------------------------------
    // One radix-2 step of the shared unsigned core
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? mag_a_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the trial difference only if it did not borrow.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, mag_b_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};

    // ------------------------------------------------------------------
    // Sign correction of the final result
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_src;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value  (acc_q),
        .negate (sa_q ^ sb_q),
        .result (prod_fixed)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value  (acc_q[WIDTH-1:0]),
        .negate (sa_q ^ sb_q),
        .result (quo_fixed)
    );

    // On divide-by-zero, re-applying A's sign to |A| reproduces a_in exactly
    // (including the most negative value), which is what HI must hold.
    assign rem_src = div0_q ? mag_a_q : acc_q[2*WIDTH-1:WIDTH];

    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value  (rem_src),
        .negate (sa_q),
        .result (rem_fixed)
    );

    // Select final HI/LO values for the FIX cycle.
    always_comb begin
        res_hi = prod_fixed[2*WIDTH-1:WIDTH];
        res_lo = prod_fixed[WIDTH-1:0];
        if (div_q) begin
            res_hi = rem_fixed;
            res_lo = div0_q ? {WIDTH{1'b1}} : quo_fixed;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Control FSM and iteration counter.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        state <= early_out ? ST_FIX : ST_CALC;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX:  state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture at launch and one core step per CALC cycle.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div0_q  <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
        end else if (launch) begin
            div_q   <= op_is_div(op_in);
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            div0_q  <= op_is_div(op_in) && b_zero;
            mag_a_q <= a_mag;
            mag_b_q <= b_mag;
            if (early_out) begin
                acc_q <= '0;
            end else begin
                acc_q <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? a_mag : b_mag)};
            end
        end else if (state == ST_CALC) begin
            acc_q <= div_q ? div_next : mul_next;
        end
    end

    // HI/LO: result write in FIX, MTHI/MTLO only while not busy.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == ST_FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (can_launch) begin
            if (hi_wr_in) begin
                hi_q <= wr_data_in;
            end
            if (lo_wr_in) begin
                lo_q <= wr_data_in;
            end
        end
    end

    assign busy_out = (state == ST_CALC) || (state == ST_FIX);
    assign done_out = (state == ST_DONE);
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH = 32.
// Latency: checks launch-to-done edge counts and busy duration.
// Backpressure: exercises starts and MTHI while busy, reset mid-operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int DZ_EDGES = 2;
    localparam int DZ_BUSY  = 1;
`else
    localparam int DZ_EDGES = 34;
    localparam int DZ_BUSY  = 33;
`endif

    logic         clk        = 1'b0;
    logic         reset_in   = 1'b0;
    logic         start_in   = 1'b0;
    logic [1:0]   op_in      = 2'b00;
    logic [W-1:0] a_in       = '0;
    logic [W-1:0] b_in       = '0;
    logic         hi_wr_in   = 1'b0;
    logic         lo_wr_in   = 1'b0;
    logic [W-1:0] wr_data_in = '0;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .start_in   (start_in),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_wr_in   (hi_wr_in),
        .lo_wr_in   (lo_wr_in),
        .wr_data_in (wr_data_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (E0); returns 1 time unit after E0.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        step();
        start_in = 1'b0;
    endtask

    // Edges counted include E0; gives up after 100 edges.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = 0;
        while (!done_out && edges < 100) begin
            if (busy_out) busy_cycles++;
            step();
            edges++;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input int exp_edges, input int exp_busy);
        int e;
        int bc;
        launch(op, a, b);
        wait_done(e, bc);
        chk({tag, "_edges"}, 64'(e), 64'(exp_edges));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        chk({tag, "_busy_at_done"}, 64'(busy_out), 64'd0);
        chk({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
        step();
        chk({tag, "_done_fall"}, 64'(done_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int bc;
        int n;
        time t1;
        time t2;

        // Reset state
        #1 reset_in = 1'b1;
        #1;
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_hi",   64'(hi_out),   64'd0);
        chk("rst_lo",   64'(lo_out),   64'd0);
        #21 reset_in = 1'b0;
        step();

        // Arithmetic vectors
        do_op("mult_neg3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34, 33);
        do_op("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 33);
        do_op("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, 33);
        do_op("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
        do_op("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33);
        do_op("divu_by0",     OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, DZ_EDGES, DZ_BUSY);
        do_op("div_neg_by0",  OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, DZ_EDGES, DZ_BUSY);

        // Start and MTHI mid-CALC are ignored
        launch(OP_MULTU, 32'd5, 32'd6);
        repeat (5) step();
        start_in   = 1'b1;
        op_in      = OP_DIVU;
        a_in       = 32'd1;
        b_in       = 32'd1;
        hi_wr_in   = 1'b1;
        wr_data_in = 32'hAAAA;
        step();
        start_in   = 1'b0;
        hi_wr_in   = 1'b0;
        chk("busy_mthi_ignored", 64'(hi_out), 64'hFFFFFFF0);
        chk("busy_still", 64'(busy_out), 64'd1);
        wait_done(e, bc);
        chk("busy_restart_edges", 64'(e), 64'd28);
        chk("busy_res_hi", 64'(hi_out), 64'd0);
        chk("busy_res_lo", 64'(lo_out), 64'd30);
        step();

        // MTHI in IDLE, then simultaneous MTHI/MTLO
        hi_wr_in   = 1'b1;
        wr_data_in = 32'h55;
        step();
        hi_wr_in   = 1'b0;
        chk("mthi_hi", 64'(hi_out), 64'h55);
        chk("mthi_lo_kept", 64'(lo_out), 64'd30);
        hi_wr_in   = 1'b1;
        lo_wr_in   = 1'b1;
        wr_data_in = 32'h77;
        step();
        hi_wr_in   = 1'b0;
        lo_wr_in   = 1'b0;
        chk("mtboth_hi", 64'(hi_out), 64'h77);
        chk("mtboth_lo", 64'(lo_out), 64'h77);

        // Reset in the middle of CALC
        launch(OP_MULTU, 32'd3, 32'd4);
        repeat (10) step();
        reset_in = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_out), 64'd0);
        chk("midrst_done", 64'(done_out), 64'd0);
        chk("midrst_hi",   64'(hi_out),   64'd0);
        chk("midrst_lo",   64'(lo_out),   64'd0);
        step();
        reset_in = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_out) n++;
            step();
        end
        chk("midrst_no_done", 64'(n), 64'd0);

        // Back-to-back: start presented while done_out is high
        launch(OP_MULTU, 32'd2, 32'd3);
        wait_done(e, bc);
        t1 = $time;
        chk("b2b_first_edges", 64'(e), 64'd34);
        chk("b2b_first_lo", 64'(lo_out), 64'd6);
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(e, bc);
        t2 = $time;
        chk("b2b_gap_cycles", 64'((t2 - t1) / 10), 64'd34);
        chk("b2b_second_hi", 64'(hi_out), 64'd2);
        chk("b2b_second_lo", 64'(lo_out), 64'd14);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
